// File: rtl/mvm_share_arbiter.sv
// mvm_share_arbiter
// Round-robin arbiter sharing one AXI-stream matrix-vector multiply engine
// between N_REQ requesters. Only one transaction is in flight at a time.
// A grant is held through the operand transfer and the result return.
//
// Ports
//   clk, rst        rising-edge clock, synchronous active-high reset
//   s_kx_*          per-requester operand streams (tdata packed, slice i = requester i)
//   e_kx_*          operand stream to the engine
//   e_y_*           result stream from the engine
//   m_y_*           per-requester result streams (tdata broadcast, qualified by tvalid)
//   grant           current or most recent granted requester
//   busy            transaction in progress (ISSUE or WAIT)
//   done_cnt        per-requester completion counters, wrap on overflow
//
// state | meaning
// ------+-----------------------------------------------
// IDLE  | no grant active, pick next requester round-robin
// ISSUE | operands of granted requester pass to the engine
// WAIT  | engine result passes back to granted requester
module mvm_share_arbiter #(
    parameter int N_REQ = 2,
    parameter int W_KX  = 224,
    parameter int W_Y   = 80,
    parameter int W_CNT = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           s_kx_tvalid,
    output logic [N_REQ-1:0]           s_kx_tready,
    input  logic [N_REQ*W_KX-1:0]      s_kx_tdata,
    output logic                       e_kx_tvalid,
    input  logic                       e_kx_tready,
    output logic [W_KX-1:0]            e_kx_tdata,
    input  logic                       e_y_tvalid,
    output logic                       e_y_tready,
    input  logic [W_Y-1:0]             e_y_tdata,
    output logic [N_REQ-1:0]           m_y_tvalid,
    input  logic [N_REQ-1:0]           m_y_tready,
    output logic [W_Y-1:0]             m_y_tdata,
    output logic [$clog2(N_REQ)-1:0]   grant,
    output logic                       busy,
    output logic [N_REQ*W_CNT-1:0]     done_cnt
);

    localparam int W_G = $clog2(N_REQ);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t                         state_q;
    state_t                         state_d;
    logic [W_G-1:0]                 grant_q;
    logic [W_G-1:0]                 last_q;
    logic [W_G-1:0]                 pick;
    logic [N_REQ-1:0][W_CNT-1:0]    cnt_q;
    logic                           kx_fire;
    logic                           y_fire;

    // First valid requester scanning last+1, last+2, ... modulo N_REQ.
    function automatic logic [W_G-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                               input logic [W_G-1:0]   prev);
        logic [W_G-1:0] sel;
        logic [W_G-1:0] cand;
        logic           found;
        sel   = '0;
        found = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = W_G'((int'(prev) + k) % N_REQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
        return sel;
    endfunction

    assign pick     = rr_pick(s_kx_tvalid, last_q);
    assign kx_fire  = (state_q == ISSUE) && s_kx_tvalid[grant_q] && e_kx_tready;
    assign y_fire   = (state_q == WAIT) && e_y_tvalid && m_y_tready[grant_q];
    assign grant    = grant_q;
    assign done_cnt = cnt_q;
    assign m_y_tdata = e_y_tdata;

    // State register and grant / completion bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= W_G'(N_REQ - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && |s_kx_tvalid) begin
                grant_q <= pick;
            end
            if (y_fire) begin
                last_q         <= grant_q;
                cnt_q[grant_q] <= cnt_q[grant_q] + W_CNT'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (|s_kx_tvalid) state_d = ISSUE;
            ISSUE:   if (kx_fire)      state_d = WAIT;
            WAIT:    if (y_fire)       state_d = IDLE;
            default:                   state_d = IDLE;
        endcase
    end

    // Operand mux follows the grant in every state; only the handshake
    // signals are gated by state.
    always_comb begin
        e_kx_tdata = s_kx_tdata[0 +: W_KX];
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_q == W_G'(i)) e_kx_tdata = s_kx_tdata[W_KX*i +: W_KX];
        end
    end

    always_comb begin
        e_kx_tvalid = 1'b0;
        s_kx_tready = '0;
        e_y_tready  = 1'b0;
        m_y_tvalid  = '0;
        busy        = (state_q != IDLE);
        case (state_q)
            ISSUE: begin
                e_kx_tvalid          = s_kx_tvalid[grant_q];
                s_kx_tready[grant_q] = e_kx_tready;
            end
            WAIT: begin
                m_y_tvalid[grant_q] = e_y_tvalid;
                e_y_tready          = m_y_tready[grant_q];
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mvm_share_arbiter.sv
module tb_mvm_share_arbiter;

    localparam int N_REQ = 2;
    localparam int W_KX  = 224;
    localparam int W_Y   = 80;
    localparam int W_CNT = 2;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic [N_REQ-1:0]        s_kx_tvalid;
    logic [N_REQ-1:0]        s_kx_tready;
    logic [N_REQ*W_KX-1:0]   s_kx_tdata;
    logic                    e_kx_tvalid;
    logic                    e_kx_tready;
    logic [W_KX-1:0]         e_kx_tdata;
    logic                    e_y_tvalid;
    logic                    e_y_tready;
    logic [W_Y-1:0]          e_y_tdata;
    logic [N_REQ-1:0]        m_y_tvalid;
    logic [N_REQ-1:0]        m_y_tready;
    logic [W_Y-1:0]          m_y_tdata;
    logic [0:0]              grant;
    logic                    busy;
    logic [N_REQ*W_CNT-1:0]  done_cnt;

    logic                    eng_kx_rdy = 1'b1;
    logic [N_REQ-1:0]        m_rdy = 2'b11;
    logic [W_Y-1:0]          early_y = '0;
    int                      early_req = 0;
    int                      early_done = 0;

    int n_chk = 0;
    int n_pass = 0;
    int n_pop = 0;
    int exp_total = 0;

    typedef struct {
        int             idx;
        logic [W_Y-1:0] y;
    } exp_t;

    exp_t            exp_q[$];
    exp_t            mon_e;
    logic [W_KX-1:0] q0[$];
    logic [W_KX-1:0] q1[$];

    assign e_kx_tready = eng_kx_rdy;
    assign m_y_tready  = m_rdy;

    always #5 clk = ~clk;

    mvm_share_arbiter #(
        .N_REQ(N_REQ), .W_KX(W_KX), .W_Y(W_Y), .W_CNT(W_CNT)
    ) dut (
        .clk(clk), .rst(rst),
        .s_kx_tvalid(s_kx_tvalid), .s_kx_tready(s_kx_tready), .s_kx_tdata(s_kx_tdata),
        .e_kx_tvalid(e_kx_tvalid), .e_kx_tready(e_kx_tready), .e_kx_tdata(e_kx_tdata),
        .e_y_tvalid(e_y_tvalid), .e_y_tready(e_y_tready), .e_y_tdata(e_y_tdata),
        .m_y_tvalid(m_y_tvalid), .m_y_tready(m_y_tready), .m_y_tdata(m_y_tdata),
        .grant(grant), .busy(busy), .done_cnt(done_cnt)
    );

    function automatic logic [W_KX-1:0] mk(input int k);
        return {7{32'h5A5A0000 | 32'(k)}};
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] expv);
        n_chk++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, expv);
    endtask

    task automatic push_req(input int r, input int k, input bit expect_y);
        logic [W_KX-1:0] d;
        exp_t            e;
        d = mk(k);
        if (r == 0) q0.push_back(d);
        else        q1.push_back(d);
        if (expect_y) begin
            e.idx = r;
            e.y   = d[W_Y-1:0];
            exp_q.push_back(e);
            exp_total++;
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        eng_kx_rdy = 1'b1;
        m_rdy = 2'b11;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (n_pop >= exp_total) begin ok = 1'b1; break; end
        end
        chk("results_timeout", 256'(ok), 256'(1));
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_kx(input int budget);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (e_kx_tvalid) begin ok = 1'b1; break; end
        end
        chk("kx_valid_timeout", 256'(ok), 256'(1));
    endtask

    task automatic wait_my(input int idx, input int budget);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (m_y_tvalid[idx]) begin ok = 1'b1; break; end
        end
        chk("m_y_valid_timeout", 256'(ok), 256'(1));
    endtask

    // Requesters: present queued operands, pop on handshake.
    initial begin
        logic [N_REQ-1:0] hs;
        s_kx_tvalid = '0;
        s_kx_tdata  = '0;
        forever begin
            @(negedge clk);
            hs = rst ? '0 : (s_kx_tvalid & s_kx_tready);
            @(posedge clk); #1;
            if (hs[0]) void'(q0.pop_front());
            if (hs[1]) void'(q1.pop_front());
            s_kx_tvalid[0] = (q0.size() > 0);
            s_kx_tvalid[1] = (q1.size() > 0);
            if (q0.size() > 0) s_kx_tdata[0 +: W_KX]    = q0[0];
            if (q1.size() > 0) s_kx_tdata[W_KX +: W_KX] = q1[0];
        end
    end

    // Engine: echo low W_Y bits of the operands after 3 compute cycles.
    // In early mode it raises a preset result before operands are taken.
    initial begin
        int              phase;
        int              cnt;
        bit              r;
        bit              kxh;
        bit              yh;
        logic [W_KX-1:0] cap_d;
        logic [W_KX-1:0] cap;
        phase = 0;
        cnt = 0;
        cap = '0;
        e_y_tvalid = 1'b0;
        e_y_tdata  = '0;
        forever begin
            @(negedge clk);
            r     = rst;
            kxh   = !rst && e_kx_tvalid && e_kx_tready;
            yh    = !rst && e_y_tvalid && e_y_tready;
            cap_d = e_kx_tdata;
            @(posedge clk); #1;
            if (r) begin
                phase = 0;
                e_y_tvalid = 1'b0;
            end else begin
                case (phase)
                    0: begin
                        if (early_req > early_done) begin
                            e_y_tvalid = 1'b1;
                            e_y_tdata  = early_y;
                        end
                        if (kxh) begin
                            if (early_req > early_done) phase = 2;
                            else begin
                                cap = cap_d;
                                cnt = 3;
                                phase = 1;
                            end
                        end
                    end
                    1: begin
                        cnt--;
                        if (cnt == 0) begin
                            e_y_tvalid = 1'b1;
                            e_y_tdata  = cap[W_Y-1:0];
                            phase = 2;
                        end
                    end
                    default: begin
                        if (yh) begin
                            e_y_tvalid = 1'b0;
                            if (early_req > early_done) early_done++;
                            phase = 0;
                        end
                    end
                endcase
            end
        end
    end

    // Monitor: every result handshake pops the scoreboard and compares.
    initial begin
        logic [N_REQ-1:0] oh;
        forever begin
            @(negedge clk);
            if (!rst) begin
                for (int i = 0; i < N_REQ; i++) begin
                    if (m_y_tvalid[i] && m_y_tready[i]) begin
                        chk("result_expected", 256'(exp_q.size() > 0), 256'(1));
                        if (exp_q.size() > 0) begin
                            mon_e = exp_q.pop_front();
                            oh = '0;
                            oh[i] = 1'b1;
                            chk("result_idx",    256'(i),          256'(mon_e.idx));
                            chk("result_data",   256'(m_y_tdata),  256'(mon_e.y));
                            chk("result_grant",  256'(grant),      256'(mon_e.idx));
                            chk("result_onehot", 256'(m_y_tvalid), 256'(oh));
                        end
                        n_pop++;
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, checks %0d", n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        logic [W_KX-1:0] d;

        // Reset state
        do_reset();
        @(negedge clk);
        chk("rst_grant",    256'(grant),       256'(0));
        chk("rst_busy",     256'(busy),        256'(0));
        chk("rst_s_ready",  256'(s_kx_tready), 256'(0));
        chk("rst_e_kx_vld", 256'(e_kx_tvalid), 256'(0));
        chk("rst_e_y_rdy",  256'(e_y_tready),  256'(0));
        chk("rst_m_y_vld",  256'(m_y_tvalid),  256'(0));
        chk("rst_done_cnt", 256'(done_cnt),    256'(0));
        chk("rst_kx_data",  256'(e_kx_tdata),  256'(0));

        // Single request from requester 0
        @(posedge clk); #1;
        push_req(0, 1, 1'b1);
        ok = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (s_kx_tvalid[0]) begin ok = 1'b1; break; end
        end
        chk("req0_raise_timeout", 256'(ok), 256'(1));
        @(negedge clk);
        chk("c1_kx_valid", 256'(e_kx_tvalid), 256'(1));
        chk("c1_kx_data",  256'(e_kx_tdata),  256'(mk(1)));
        chk("c1_grant",    256'(grant),       256'(0));
        chk("c1_busy",     256'(busy),        256'(1));
        chk("c1_s_ready",  256'(s_kx_tready), 256'(2'b01));
        wait_done(50);
        chk("t1_done_cnt", 256'(done_cnt), 256'(4'b0001));
        chk("t1_grant",    256'(grant),    256'(0));
        chk("t1_busy",     256'(busy),     256'(0));

        // Both requesters continuously valid: order 0,1,0,1,0,1
        do_reset();
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            push_req(0, 10 + k, 1'b1);
            push_req(1, 20 + k, 1'b1);
        end
        wait_done(300);
        chk("t2_done_cnt", 256'(done_cnt), 256'(4'b1111));

        // Back-pressure on operand and result paths
        do_reset();
        @(posedge clk); #1;
        eng_kx_rdy = 1'b0;
        m_rdy = 2'b01;
        push_req(1, 30, 1'b1);
        wait_kx(20);
        for (int c = 0; c < 5; c++) begin
            chk("stall_kx_valid", 256'(e_kx_tvalid), 256'(1));
            chk("stall_kx_data",  256'(e_kx_tdata),  256'(mk(30)));
            chk("stall_s_ready",  256'(s_kx_tready), 256'(0));
            chk("stall_grant",    256'(grant),       256'(1));
            if (c < 4) @(negedge clk);
        end
        @(posedge clk); #1;
        eng_kx_rdy = 1'b1;
        wait_my(1, 20);
        d = mk(30);
        for (int c = 0; c < 4; c++) begin
            chk("stall_m_y_valid", 256'(m_y_tvalid), 256'(2'b10));
            chk("stall_m_y_data",  256'(m_y_tdata),  256'(d[W_Y-1:0]));
            chk("stall_e_y_ready", 256'(e_y_tready), 256'(0));
            chk("stall_done_cnt",  256'(done_cnt),   256'(0));
            if (c < 3) @(negedge clk);
        end
        @(posedge clk); #1;
        m_rdy = 2'b11;
        wait_done(50);
        chk("t3_done_cnt", 256'(done_cnt), 256'(4'b0100));

        // Engine result raised during ISSUE is held off until WAIT
        do_reset();
        @(posedge clk); #1;
        eng_kx_rdy = 1'b0;
        d = mk(40);
        early_y = d[W_Y-1:0];
        early_req++;
        push_req(0, 40, 1'b1);
        wait_kx(20);
        for (int c = 0; c < 3; c++) begin
            chk("early_e_y_ready", 256'(e_y_tready), 256'(0));
            chk("early_m_y_valid", 256'(m_y_tvalid), 256'(0));
            if (c < 2) @(negedge clk);
        end
        @(posedge clk); #1;
        eng_kx_rdy = 1'b1;
        wait_done(50);
        repeat (8) @(negedge clk);
        chk("early_deliveries", 256'(n_pop),    256'(exp_total));
        chk("t4_done_cnt",      256'(done_cnt), 256'(4'b0001));

        // Reset during WAIT discards the transaction
        do_reset();
        @(posedge clk); #1;
        m_rdy = 2'b10;
        push_req(0, 50, 1'b0);
        wait_my(0, 20);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("wrst_m_y_vld",  256'(m_y_tvalid),  256'(0));
        chk("wrst_e_y_rdy",  256'(e_y_tready),  256'(0));
        chk("wrst_s_ready",  256'(s_kx_tready), 256'(0));
        chk("wrst_e_kx_vld", 256'(e_kx_tvalid), 256'(0));
        chk("wrst_busy",     256'(busy),        256'(0));
        chk("wrst_done_cnt", 256'(done_cnt),    256'(0));
        chk("wrst_grant",    256'(grant),       256'(0));
        @(posedge clk); #1;
        m_rdy = 2'b11;
        push_req(1, 60, 1'b1);
        wait_kx(20);
        chk("wrst_next_grant", 256'(grant), 256'(1));
        wait_done(50);
        chk("t5_done_cnt", 256'(done_cnt), 256'(4'b0100));

        // Counter wrap: 5 completions on a 2-bit counter
        do_reset();
        @(posedge clk); #1;
        for (int k = 0; k < 5; k++) push_req(0, 70 + k, 1'b1);
        wait_done(300);
        chk("wrap_done_cnt", 256'(done_cnt), 256'(4'b0001));
        chk("wrap_grant",    256'(grant),    256'(0));
        chk("final_pops",    256'(n_pop),    256'(exp_total));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mvm_share_arbiter.md
# mvm_share_arbiter

Round-robin arbiter that shares one AXI-stream matrix-vector multiply engine between N_REQ independent requesters. Each requester presents a packed K/X operand bus. The arbiter grants one requester, forwards its operands to the engine, and routes the engine's single Y result back to that requester before granting again. It sits between the UART/host front-ends and the matvec engine, and allows exactly one transaction in flight.

## Interface
- N_REQ, 2, number of requesters (≥2)
- W_KX, 224, operand bus width (R*C*W_K + C*W_X for R=C=8, W_X=4, W_K=3)
- W_Y, 80, result bus width (R*(W_X+W_K+clog2(C)))
- W_CNT, 16, width of per-requester completion counters

Ports:
- clk  in  1  sole clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- s_kx_tvalid  in  N_REQ  per-requester operand valid
- s_kx_tready  out  N_REQ  per-requester operand ready
- s_kx_tdata  in  N_REQ*W_KX  requester i operands at [W_KX*i +: W_KX]
- e_kx_tvalid  out  1  operand valid to engine
- e_kx_tready  in  1  engine operand ready
- e_kx_tdata  out  W_KX  operands to engine
- e_y_tvalid  in  1  engine result valid
- e_y_tready  out  1  result ready to engine
- e_y_tdata  in  W_Y  engine result
- m_y_tvalid  out  N_REQ  per-requester result valid
- m_y_tready  in  N_REQ  per-requester result ready
- m_y_tdata  out  W_Y  result, broadcast to all requesters (qualified by m_y_tvalid)
- grant  out  clog2(N_REQ)  current/last granted requester
- busy  out  1  high in ISSUE or WAIT
- done_cnt  out  N_REQ*W_CNT  completed transactions per requester

## Operation
- FSM states:
  - IDLE: no grant active.
  - ISSUE: operand transfer to the engine.
  - WAIT: result return to the requester.
- IDLE: if any s_kx_tvalid, register grant = first valid index scanning last+1, last+2, … mod N_REQ, then go to ISSUE. Otherwise stay in IDLE.
- ISSUE:
  - e_kx_tvalid = s_kx_tvalid[grant].
  - e_kx_tdata = slice grant of s_kx_tdata (combinational mux).
  - s_kx_tready[grant] = e_kx_tready. All other s_kx_tready are 0.
  - On e_kx_tvalid & e_kx_tready, go to WAIT.
- WAIT:
  - m_y_tvalid[grant] = e_y_tvalid. All others are 0.
  - e_y_tready = m_y_tready[grant].
  - m_y_tdata = e_y_tdata.
  - On handshake: last = grant, done_cnt[grant] += 1 (wraps at 2^W_CNT), go to IDLE.
- Outside their state, e_kx_tvalid, e_y_tready, all s_kx_tready and all m_y_tvalid are 0.
- e_y_tvalid arriving in IDLE or ISSUE is not accepted (e_y_tready = 0). This is a protocol error by the engine and is held off, not dropped.
- Requesters obey AXIS: once tvalid is raised, hold it and tdata until the handshake. The arbiter never withdraws a grant.
- Reset values:
  - State IDLE, grant 0, last = N_REQ-1 (requester 0 wins first), done_cnt all 0, busy 0.
  - All tvalid/tready outputs 0.
  - e_kx_tdata follows the mux of slice 0.
  - m_y_tdata follows e_y_tdata.
- Reset mid-transaction returns to IDLE and discards the grant. The engine shares rst, so no stale result survives.

## Timing
- Request raised in IDLE at cycle 0: grant registers at edge 0→1, and e_kx_tvalid is high in cycle 1.
- Operand path is combinational (zero-latency pass-through) while in ISSUE.
- Result path is combinational while in WAIT.
- Result handshake at cycle n: IDLE at n+1. A pending request is granted at the n+1→n+2 edge, giving a minimum 1-cycle IDLE bubble between transactions.
- Back-pressure: e_kx_tready or m_y_tready low stalls ISSUE or WAIT indefinitely with no timeout.
- Simultaneous requests resolve in round-robin order. With all requesters continuously valid, each is served once per N_REQ transactions.
- A requester dropping tvalid before grant is legal. If no valid remains in IDLE, stay in IDLE.

## Test plan
- Reset then single request, engine echo-model with 3-cycle compute:
  - s_kx_tvalid = 01, data A.
  - e_kx_tdata = A in cycle 1.
  - Result Y reaches m_y_tvalid[0] only.
  - done_cnt[0] = 1, grant = 0.
- Both requesters valid continuously for 6 transactions: grant order is 0,1,0,1,0,1 and done_cnt = {3,3}.
- Back-pressure:
  - Hold e_kx_tready low 5 cycles, then m_y_tready[1] low 4 cycles.
  - No handshake occurs while low, and outputs stay stable.
  - Exactly one completion is counted.
- Engine asserts e_y_tvalid during ISSUE: e_y_tready stays 0 until WAIT, and the result is delivered once.
- Assert rst during WAIT:
  - Next cycle is IDLE with all valids/readies 0, done_cnt 0, last = 1.
  - The next request from requester 1 alone is granted.
- Counter wrap with W_CNT = 2: 5 transactions from requester 0 give done_cnt[0] = 1.
